// File: rtl/jtag_tap_sampled.sv
// ============================================================================
// Module  : jtag_tap_sampled
// Purpose : Oversampled JTAG TAP (IDCODE, BYPASS, one user DR with an update
//           valid/ready handshake). Optional JTAG_TAP_SYNC_EN adds 2-flop
//           input synchronizers for asynchronous pins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_sampled #(
    parameter int unsigned          IrWidth     = 5,
    parameter int unsigned          DrWidth     = 32,
    parameter logic [31:0]          IdcodeValue = 32'h2000_1A6F,
    parameter logic [IrWidth-1:0]   UserInstr   = 5'h10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               jtag_tck_i,
    input  logic               jtag_tms_i,
    input  logic               jtag_tdi_i,
    input  logic               jtag_trst_ni,
    output logic               jtag_tdo_o,
    output logic               jtag_tdo_oe_o,
    output logic [3:0]         tap_state_o,
    output logic [IrWidth-1:0] ir_o,
    input  logic [DrWidth-1:0] dr_cap_data_i,
    output logic               dr_upd_valid_o,
    input  logic               dr_upd_ready_i,
    output logic [DrWidth-1:0] dr_upd_data_o,
    output logic               dr_overrun_o
);

    localparam logic [3:0] TLR      = 4'hF;
    localparam logic [3:0] RTI      = 4'hC;
    localparam logic [3:0] SEL_DR   = 4'h7;
    localparam logic [3:0] CAP_DR   = 4'h6;
    localparam logic [3:0] SH_DR    = 4'h2;
    localparam logic [3:0] EX1_DR   = 4'h1;
    localparam logic [3:0] PAUSE_DR = 4'h3;
    localparam logic [3:0] EX2_DR   = 4'h0;
    localparam logic [3:0] UPD_DR   = 4'h5;
    localparam logic [3:0] SEL_IR   = 4'h4;
    localparam logic [3:0] CAP_IR   = 4'hE;
    localparam logic [3:0] SH_IR    = 4'hA;
    localparam logic [3:0] EX1_IR   = 4'h9;
    localparam logic [3:0] PAUSE_IR = 4'hB;
    localparam logic [3:0] EX2_IR   = 4'h8;
    localparam logic [3:0] UPD_IR   = 4'hD;

    localparam logic [IrWidth-1:0] IR_IDCODE  = IrWidth'(1);
    localparam logic [IrWidth-1:0] IR_CAPTURE = IrWidth'(1);

    logic tck, tms, tdi, trst_n, tck_q;

`ifdef JTAG_TAP_SYNC_EN
    logic [1:0] tck_sync, tms_sync, tdi_sync, trst_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_sync  <= 2'b00;
            tms_sync  <= 2'b00;
            tdi_sync  <= 2'b00;
            trst_sync <= 2'b11;
        end else begin
            tck_sync  <= {tck_sync[0], jtag_tck_i};
            tms_sync  <= {tms_sync[0], jtag_tms_i};
            tdi_sync  <= {tdi_sync[0], jtag_tdi_i};
            trst_sync <= {trst_sync[0], jtag_trst_ni};
        end
    end

    assign tck    = tck_sync[1];
    assign tms    = tms_sync[1];
    assign tdi    = tdi_sync[1];
    assign trst_n = trst_sync[1];
`else
    assign tck    = jtag_tck_i;
    assign tms    = jtag_tms_i;
    assign tdi    = jtag_tdi_i;
    assign trst_n = jtag_trst_ni;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tck_q <= 1'b0;
        else         tck_q <= tck;
    end

    // Test reset wins over any TCK edge seen in the same cycle.
    logic rise, fall;
    assign rise = tck & ~tck_q & trst_n;
    assign fall = ~tck & tck_q & trst_n;

    logic [3:0] state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= TLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!trst_n) begin
            state_d = TLR;
        end else if (rise) begin
            case (state_q)
                TLR:      state_d = tms ? TLR      : RTI;
                RTI:      state_d = tms ? SEL_DR   : RTI;
                SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
                CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
                SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
                EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
                EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
                UPD_DR:   state_d = tms ? SEL_DR   : RTI;
                SEL_IR:   state_d = tms ? TLR      : CAP_IR;
                CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
                SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
                EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
                EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
                UPD_IR:   state_d = tms ? SEL_DR   : RTI;
                default:  state_d = TLR;
            endcase
        end
    end

    logic [IrWidth-1:0] ir_sr;
    logic [31:0]        idcode_sr;
    logic               bypass_sr;
    logic [DrWidth-1:0] user_sr;

    logic sel_idcode, sel_user, sel_bypass;
    logic cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, in_reset, tdo_next;

    always_comb begin
        sel_idcode = (ir_o == IR_IDCODE);
        sel_user   = !sel_idcode && (ir_o == UserInstr);
        sel_bypass = !sel_idcode && !sel_user;
        cap_ir     = (state_q == CAP_IR);
        sh_ir      = (state_q == SH_IR);
        upd_ir     = (state_q == UPD_IR);
        cap_dr     = (state_q == CAP_DR);
        sh_dr      = (state_q == SH_DR);
        upd_dr     = (state_q == UPD_DR);
        in_reset   = (state_q == TLR) || !trst_n;
        tdo_next   = 1'b0;
        if (sh_ir) begin
            tdo_next = ir_sr[0];
        end else if (sh_dr) begin
            if (sel_idcode)    tdo_next = idcode_sr[0];
            else if (sel_user) tdo_next = user_sr[0];
            else               tdo_next = bypass_sr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_sr     <= '0;
            idcode_sr <= '0;
            bypass_sr <= 1'b0;
            user_sr   <= '0;
        end else if (rise) begin
            if (cap_ir)     ir_sr <= IR_CAPTURE;
            else if (sh_ir) ir_sr <= {tdi, ir_sr[IrWidth-1:1]};
            if (cap_dr) begin
                if (sel_idcode) idcode_sr <= IdcodeValue;
                if (sel_bypass) bypass_sr <= 1'b0;
                if (sel_user)   user_sr   <= dr_cap_data_i;
            end else if (sh_dr) begin
                if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
                if (sel_bypass) bypass_sr <= tdi;
                if (sel_user)   user_sr   <= {tdi, user_sr[DrWidth-1:1]};
            end
        end
    end

    logic upd_fire;
    assign upd_fire = fall && upd_dr && (ir_o == UserInstr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            jtag_tdo_o     <= 1'b0;
            jtag_tdo_oe_o  <= 1'b0;
            ir_o           <= IR_IDCODE;
            dr_upd_valid_o <= 1'b0;
            dr_upd_data_o  <= '0;
            dr_overrun_o   <= 1'b0;
        end else begin
            if (fall) begin
                jtag_tdo_o    <= tdo_next;
                jtag_tdo_oe_o <= sh_ir || sh_dr;
            end
            if (in_reset)          ir_o <= IR_IDCODE;
            else if (fall && upd_ir) ir_o <= ir_sr;
            // An accept on the same edge frees the slot, so the new word is taken.
            if (upd_fire) begin
                if (dr_upd_valid_o && !dr_upd_ready_i) begin
                    dr_overrun_o <= 1'b1;
                end else begin
                    dr_upd_data_o  <= user_sr;
                    dr_upd_valid_o <= 1'b1;
                end
            end else if (dr_upd_valid_o && dr_upd_ready_i) begin
                dr_upd_valid_o <= 1'b0;
            end
            if (in_reset) dr_overrun_o <= 1'b0;
        end
    end

    assign tap_state_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_sampled.sv
// Self-checking bench for jtag_tap_sampled: state walk, IDCODE/BYPASS/USER
// scans, update handshake, overrun, test reset.
`timescale 1ns/1ps
`default_nettype none

module tb_jtag_tap_sampled;

    localparam int          HALF   = 4;
    localparam logic [31:0] IDCODE = 32'h2000_1A6F;
    localparam logic [4:0]  USER   = 5'h10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
    logic        tdo, tdo_oe;
    logic [3:0]  tap_state;
    logic [4:0]  ir;
    logic [31:0] cap_data = '0;
    logic        upd_valid, upd_ready = 1'b0, overrun;
    logic [31:0] upd_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    typedef struct {
        logic       tms;
        logic [3:0] exp_state;
    } vec_t;
    vec_t vecs[4];

    always #5 clk_i = ~clk_i;

    jtag_tap_sampled dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .jtag_tck_i     (tck),
        .jtag_tms_i     (tms),
        .jtag_tdi_i     (tdi),
        .jtag_trst_ni   (trst_n),
        .jtag_tdo_o     (tdo),
        .jtag_tdo_oe_o  (tdo_oe),
        .tap_state_o    (tap_state),
        .ir_o           (ir),
        .dr_cap_data_i  (cap_data),
        .dr_upd_valid_o (upd_valid),
        .dr_upd_ready_i (upd_ready),
        .dr_upd_data_o  (upd_data),
        .dr_overrun_o   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One TCK period: low phase (TDO sampled at its end), then high phase.
    task automatic tck_cycle(input logic t_ms, input logic t_di,
                             output logic tdo_s, output logic oe_s, output logic [3:0] st_first);
        @(negedge clk_i);
        tck = 1'b0; tms = t_ms; tdi = t_di;
        repeat (HALF) @(negedge clk_i);
        tdo_s = tdo;
        oe_s  = tdo_oe;
        tck   = 1'b1;
        @(posedge clk_i);
        #1 st_first = tap_state;
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic tms_seq(input logic [7:0] bits, input int n);
        logic b, o;
        logic [3:0] s;
        for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'b0, b, o, s);
    endtask

    task automatic shift(input string name, input int n, input logic [31:0] din, input logic [31:0] dexp);
        logic b, o;
        logic [3:0] s;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(dexp[i]);
            tck_cycle(i == n - 1, din[i], b, o, s);
            check($sformatf("%s[%0d]", name, i), {31'b0, b}, {31'b0, exp_q.pop_front()});
        end
    endtask

    // From RTI: load an IR value and return to RTI.
    task automatic load_ir(input logic [4:0] val);
        tms_seq(8'b0000_0011, 4);
        shift("ir_capture", 5, {27'b0, val}, 32'h0000_0001);
        tms_seq(8'b0000_0001, 2);
    endtask

    // From RTI: full DR scan, back to RTI.
    task automatic dr_scan(input string name, input int n, input logic [31:0] din, input logic [31:0] dexp);
        tms_seq(8'b0000_0001, 3);
        shift(name, n, din, dexp);
        tms_seq(8'b0000_0001, 2);
    endtask

    initial begin
        logic b, o;
        logic [3:0] s;

        vecs[0] = '{tms: 1'b0, exp_state: 4'hC};
        vecs[1] = '{tms: 1'b1, exp_state: 4'h7};
        vecs[2] = '{tms: 1'b0, exp_state: 4'h6};
        vecs[3] = '{tms: 1'b0, exp_state: 4'h2};

        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_state", {28'b0, tap_state}, 32'hF);
        check("rst_ir", {27'b0, ir}, 32'h01);
        check("rst_tdo", {31'b0, tdo}, 0);
        check("rst_oe", {31'b0, tdo_oe}, 0);
        check("rst_valid", {31'b0, upd_valid}, 0);
        check("rst_data", upd_data, 0);
        check("rst_overrun", {31'b0, overrun}, 0);

        // State walk to ShDR; state must change on first clk that sees TCK high.
        for (int i = 0; i < 4; i++) begin
            tck_cycle(vecs[i].tms, 1'b0, b, o, s);
            check($sformatf("walk_state[%0d]", i), {28'b0, s}, {28'b0, vecs[i].exp_state});
        end
        shift("idcode", 32, 32'h0, IDCODE);
        tms_seq(8'b0000_0001, 2);

        // BYPASS via all-ones IR
        load_ir(5'h1F);
        check("ir_bypass", {27'b0, ir}, 32'h1F);
        dr_scan("bypass", 8, 32'hA5, (32'hA5 << 1) & 32'hFF);

        // USER capture/update
        load_ir(USER);
        check("ir_user", {27'b0, ir}, {27'b0, USER});
        cap_data = 32'hDEAD_BEEF;
        dr_scan("user_cap", 32, 32'h1234_5678, 32'hDEAD_BEEF);
        check("upd_valid", {31'b0, upd_valid}, 1);
        check("upd_data", upd_data, 32'h1234_5678);
        repeat (20) @(negedge clk_i);
        check("upd_valid_hold", {31'b0, upd_valid}, 1);
        check("upd_data_hold", upd_data, 32'h1234_5678);

        // Second update while pending -> overrun, first word kept
        dr_scan("user_cap2", 32, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        check("ovr_valid", {31'b0, upd_valid}, 1);
        check("ovr_data", upd_data, 32'h1234_5678);
        check("ovr_flag", {31'b0, overrun}, 1);
        tms_seq(8'b0001_1111, 5);
        check("tlr_state", {28'b0, tap_state}, 32'hF);
        check("tlr_overrun", {31'b0, overrun}, 0);
        check("tlr_ir", {27'b0, ir}, 32'h01);
        check("tlr_valid_kept", {31'b0, upd_valid}, 1);
        check("tlr_data_kept", upd_data, 32'h1234_5678);
        @(negedge clk_i); upd_ready = 1'b1;
        @(negedge clk_i); upd_ready = 1'b0;
        check("accept_clears", {31'b0, upd_valid}, 0);

        // Test reset during ShDR
        tms_seq(8'b0000_0010, 4);
        tck_cycle(1'b0, 1'b1, b, o, s);
        check("shdr_oe", {31'b0, o}, 1);
        check("shdr_state", {28'b0, s}, 32'h2);
        @(negedge clk_i); trst_n = 1'b0;
        @(negedge clk_i); trst_n = 1'b1;
        check("trst_state", {28'b0, tap_state}, 32'hF);
        tck_cycle(1'b1, 1'b0, b, o, s);
        check("trst_tdo", {31'b0, b}, 0);
        check("trst_oe", {31'b0, o}, 0);

        // Same-edge update and accept
        tms_seq(8'b0000_0000, 1);
        load_ir(USER);
        cap_data = 32'h0F0F_0F0F;
        dr_scan("word_a", 32, 32'h1111_1111, 32'h0F0F_0F0F);
        check("word_a_valid", {31'b0, upd_valid}, 1);
        tms_seq(8'b0000_0001, 3);
        shift("word_b", 32, 32'h2222_2222, 32'h0F0F_0F0F);
        tck_cycle(1'b1, 1'b0, b, o, s);
        check("upddr_state", {28'b0, s}, 32'h5);
        @(negedge clk_i);
        tck = 1'b0; tms = 1'b0; upd_ready = 1'b1;
        @(negedge clk_i);
        upd_ready = 1'b0;
        check("same_edge_valid", {31'b0, upd_valid}, 1);
        check("same_edge_data", upd_data, 32'h2222_2222);
        check("same_edge_overrun", {31'b0, overrun}, 0);
        repeat (HALF - 1) @(negedge clk_i);
        tck = 1'b1;
        repeat (HALF) @(negedge clk_i);
        check("back_to_rti", {28'b0, tap_state}, 32'hC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
